scan_code_unloader: RTL

//  Drains the 8-entry PS/2 scan-code history register into the VGA text path, one byte at a time.
//  On a start pulse it snapshots all slots in parallel, then streams them oldest-first over a

---
 rtl/scan_code_unloader_pkg.sv | 20 ++
 rtl/scan_code_unloader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/scan_code_unloader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : scan_unload_defs (package)
// Brief   : Shared FSM encodings and default geometry for the scan-code history path.
// Revision: 1.0 - initial release
// ============================================================================
package scan_unload_defs;

    localparam int c_DEF_DEPTH = 8;
    localparam int c_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        c_ST_IDLE = 2'd0,
        c_ST_SCAN = 2'd1,
        c_ST_SEND = 2'd2,
        c_ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scan_code_unloader.sv
`default_nettype none
// ============================================================================
// Module  : scan_code_unloader
// Brief   : Snapshots the scan-code history slots and streams them oldest-first
//           over a valid/ready handshake, optionally skipping empty slots.
// Revision: 1.0 - initial release
// ============================================================================
module scan_code_unloader
    import scan_unload_defs::*;
#(
    parameter int DEPTH     = c_DEF_DEPTH,
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int SKIP_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DEPTH*WIDTH-1:0]   vin,
    input  logic                     start,
    input  logic                     byte_ready,
    output logic                     byte_valid,
    output logic [WIDTH-1:0]         byte_data,
    output logic [$clog2(DEPTH)-1:0] byte_idx,
    output logic                     last,
    output logic                     busy,
    output logic                     done
);

    localparam int             c_IW   = $clog2(DEPTH);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(DEPTH - 1);
    localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);

    state_t            r_state;
    logic [WIDTH-1:0]  r_snap [DEPTH];
    logic [c_IW-1:0]   r_idx;
    logic              r_byte_valid;
    logic [WIDTH-1:0]  r_byte_data;
    logic [c_IW-1:0]   r_byte_idx;
    logic              r_last;
    logic              r_busy;
    logic              r_done;

    logic [WIDTH-1:0]  w_cur;
    logic              w_at_last;
    logic              w_skip;

    // DEPTH:1 snapshot mux; idx never exceeds DEPTH-1 so the read is always in range
    assign w_cur     = r_snap[r_idx];
    assign w_at_last = (r_idx == c_LAST);
    assign w_skip    = (SKIP_ZERO != 0) && (w_cur == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            for (int k = 0; k < DEPTH; k++) begin
                r_snap[k] <= '0;
            end
            r_idx        <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_byte_idx   <= '0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            r_snap[k] <= vin[k*WIDTH +: WIDTH];
                        end
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_SCAN;
                    end
                end
                c_ST_SCAN: begin
                    if (w_skip) begin
                        if (w_at_last) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_idx <= r_idx + c_ONE;
                        end
                    end else begin
                        r_byte_data  <= w_cur;
                        r_byte_idx   <= r_idx;
                        r_byte_valid <= 1'b1;
                        r_last       <= w_at_last;
                        r_state      <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (byte_ready) begin
                        r_byte_valid <= 1'b0;
                        r_last       <= 1'b0;
                        if (w_at_last) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_idx   <= r_idx + c_ONE;
                            r_state <= c_ST_SCAN;
                        end
                    end
                end
                c_ST_DONE: begin
                    // start is deliberately not sampled here, so it cannot chain a new drain
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign byte_idx   = r_byte_idx;
    assign last       = r_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire
